// File: rtl/pixel_stream_feeder.sv
// Ready/valid to no-backpressure pixel feeder for the line-buffered window generator.
// Line-credit flow control keeps downstream line buffers from being overwritten; also frames lines/frames.
module pixel_stream_feeder #(
   parameter int LINE_WIDTH    = 480,
   parameter int NUM_LINE_BUFS = 7,
   parameter int IMG_HEIGHT    = 480
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst,
   input  logic                                 i_start,
   input  logic [7:0]                           i_s_data,
   input  logic                                 i_s_valid,
   output logic                                 o_s_ready,
   output logic [7:0]                           o_pixel_data,
   output logic                                 o_pixel_data_valid,
   input  logic                                 i_intr,
   output logic [$clog2(NUM_LINE_BUFS+1)-1:0]   o_credit,
   output logic                                 o_stall,
   output logic                                 o_line_done,
   output logic                                 o_frame_done,
   output logic                                 o_err
);

   localparam int PW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
   localparam int LW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int CW = $clog2(NUM_LINE_BUFS + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [PW-1:0] PIX_LAST   = PW'(LINE_WIDTH - 1);
   localparam logic [PW-1:0] PIX_ONE    = PW'(1);
   localparam logic [LW-1:0] LINE_LAST  = LW'(IMG_HEIGHT - 1);
   localparam logic [LW-1:0] LINE_ONE   = LW'(1);
   localparam logic [CW-1:0] CREDIT_MAX = CW'(NUM_LINE_BUFS);
   localparam logic [CW-1:0] CREDIT_ONE = CW'(1);

   logic [1:0]    state_r;
   logic [1:0]    state_nxt_s;
   logic [PW-1:0] pix_cnt_r;
   logic [LW-1:0] line_cnt_r;
   logic [CW-1:0] credit_r;
   logic [CW-1:0] credit_nxt_s;
   logic [7:0]    data_r;
   logic          valid_r;
   logic          line_done_r;
   logic          frame_done_r;
   logic          err_r;
   logic          err_set_s;
   logic          ready_s;
   logic          stall_s;
   logic          accept_s;
   logic          consume_s;
   logic          line_end_s;
   logic          frame_end_s;

   // Source handshake: a new line may only start once a free line buffer is reserved.
   always_comb begin
      ready_s = 1'b0;
      stall_s = 1'b0;
      if (state_r == ST_SEND) begin
         ready_s = (pix_cnt_r != '0) || (credit_r != '0);
         stall_s = (pix_cnt_r == '0) && (credit_r == '0);
      end else begin
         ready_s = 1'b0;
         stall_s = 1'b0;
      end
   end

   assign accept_s    = i_s_valid && ready_s;
   assign consume_s   = accept_s && (pix_cnt_r == '0);
   assign line_end_s  = accept_s && (pix_cnt_r == PIX_LAST);
   assign frame_end_s = line_end_s && (line_cnt_r == LINE_LAST);

   // Frame sequencing.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (i_start) begin
               state_nxt_s = ST_SEND;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (frame_end_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_SEND;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Credit bookkeeping; a return at full credit means the generator over-reported, so flag it.
   always_comb begin
      credit_nxt_s = credit_r;
      err_set_s    = 1'b0;
      if (i_intr && !consume_s) begin
         if (credit_r == CREDIT_MAX) begin
            credit_nxt_s = credit_r;
            err_set_s    = 1'b1;
         end else begin
            credit_nxt_s = credit_r + CREDIT_ONE;
            err_set_s    = 1'b0;
         end
      end else if (consume_s && !i_intr) begin
         credit_nxt_s = credit_r - CREDIT_ONE;
      end else begin
         credit_nxt_s = credit_r;
      end
   end

   // Registered state, counters and generator-facing outputs.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_r      <= ST_IDLE;
         pix_cnt_r    <= '0;
         line_cnt_r   <= '0;
         credit_r     <= CREDIT_MAX;
         data_r       <= 8'd0;
         valid_r      <= 1'b0;
         line_done_r  <= 1'b0;
         frame_done_r <= 1'b0;
         err_r        <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         credit_r     <= credit_nxt_s;
         err_r        <= err_r | err_set_s;
         valid_r      <= accept_s;
         line_done_r  <= line_end_s;
         frame_done_r <= frame_end_s;
         if (accept_s) begin
            data_r <= i_s_data;
            if (pix_cnt_r == PIX_LAST) begin
               pix_cnt_r <= '0;
               if (line_cnt_r == LINE_LAST) begin
                  line_cnt_r <= '0;
               end else begin
                  line_cnt_r <= line_cnt_r + LINE_ONE;
               end
            end else begin
               pix_cnt_r <= pix_cnt_r + PIX_ONE;
            end
         end
      end
   end

   assign o_s_ready          = ready_s;
   assign o_stall            = stall_s;
   assign o_pixel_data       = data_r;
   assign o_pixel_data_valid = valid_r;
   assign o_line_done        = line_done_r;
   assign o_frame_done       = frame_done_r;
   assign o_err              = err_r;
   assign o_credit           = credit_r;

endmodule

// File: tb/tb_pixel_stream_feeder.sv
// Bench for pixel_stream_feeder: hand-written vector table, directed sequences and random
// stimulus, all checked against a pixel/credit counting reference model.
module tb_pixel_stream_feeder;

   localparam int LW = 8;
   localparam int NB = 3;
   localparam int IH = 5;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b0;
   logic       i_start = 1'b0;
   logic [7:0] i_s_data = 8'd0;
   logic       i_s_valid = 1'b0;
   logic       i_intr = 1'b0;
   logic       o_s_ready;
   logic [7:0] o_pixel_data;
   logic       o_pixel_data_valid;
   logic [1:0] o_credit;
   logic       o_stall;
   logic       o_line_done;
   logic       o_frame_done;
   logic       o_err;

   pixel_stream_feeder #(.LINE_WIDTH(LW), .NUM_LINE_BUFS(NB), .IMG_HEIGHT(IH)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_s_data(i_s_data),
      .i_s_valid(i_s_valid), .o_s_ready(o_s_ready), .o_pixel_data(o_pixel_data),
      .o_pixel_data_valid(o_pixel_data_valid), .i_intr(i_intr), .o_credit(o_credit),
      .o_stall(o_stall), .o_line_done(o_line_done), .o_frame_done(o_frame_done), .o_err(o_err)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_pass = 0;

   // Reference model: frame-level pixel count and credit as plain integers.
   bit         m_active, m_done, m_err;
   int         m_sent, m_credit;
   bit         e_valid, e_ld, e_fd;
   logic [7:0] e_data;

   typedef struct {
      logic       start;
      logic       valid;
      logic [7:0] data;
      logic       intr;
      logic       exp_ready;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic [1:0] exp_credit;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_active = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_sent = 0; m_credit = NB;
      e_valid = 1'b0; e_ld = 1'b0; e_fd = 1'b0; e_data = 8'd0;
   endtask

   // Holds reset for two edges (source inputs left as the caller set them), then releases.
   task automatic do_reset();
      i_rst = 1'b0; i_start = 1'b0; i_intr = 1'b0;
      @(posedge i_clk); #1;
      check("rst_valid", o_pixel_data_valid, 0);
      check("rst_data", o_pixel_data, 0);
      check("rst_credit", o_credit, NB);
      check("rst_ready", o_s_ready, 0);
      check("rst_stall", o_stall, 0);
      check("rst_line_done", o_line_done, 0);
      check("rst_frame_done", o_frame_done, 0);
      check("rst_err", o_err, 0);
      @(posedge i_clk); #1;
      i_rst = 1'b1;
      i_s_valid = 1'b0;
      model_reset();
   endtask

   task automatic cycle(input bit start, input bit valid, input logic [7:0] data, input bit intr);
      bit ready_m, acc, consume;
      int c;
      i_start = start; i_s_valid = valid; i_s_data = data; i_intr = intr;
      #2;
      ready_m = m_active && ((m_sent % LW) != 0 || m_credit > 0);
      check("s_ready", o_s_ready, ready_m);
      check("stall", o_stall, m_active && (m_sent % LW) == 0 && m_credit == 0);
      acc = valid && ready_m;
      consume = acc && (m_sent % LW) == 0;
      c = m_credit - int'(consume) + int'(intr);
      if (c > NB) begin
         c = NB;
         m_err = 1'b1;
      end
      m_credit = c;
      if (m_done) m_done = 1'b0;
      else if (!m_active && start) m_active = 1'b1;
      e_valid = acc; e_ld = 1'b0; e_fd = 1'b0;
      if (acc) begin
         e_data = data;
         m_sent++;
         if (m_sent % LW == 0) e_ld = 1'b1;
         if (m_sent == LW * IH) begin
            m_sent = 0; m_active = 1'b0; m_done = 1'b1; e_fd = 1'b1;
         end
      end
      @(posedge i_clk); #1;
      check("pix_valid", o_pixel_data_valid, e_valid);
      check("pix_data", o_pixel_data, e_data);
      check("line_done", o_line_done, e_ld);
      check("frame_done", o_frame_done, e_fd);
      check("err", o_err, m_err);
      check("credit", o_credit, m_credit);
   endtask

   initial begin
      // {start, valid, data, intr} -> {ready during cycle, valid/data/credit after edge}
      tbl[0] = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, 2'd3};
      tbl[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd3};
      tbl[2] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 2'd2};
      tbl[3] = '{1'b0, 1'b0, 8'h77, 1'b0, 1'b1, 1'b0, 8'h11, 2'd2};
      tbl[4] = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h22, 2'd3};
      tbl[5] = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h33, 2'd3};

      do_reset();
      for (int i = 0; i < 6; i++) begin
         i_start = tbl[i].start; i_s_valid = tbl[i].valid;
         i_s_data = tbl[i].data; i_intr = tbl[i].intr;
         #2;
         check($sformatf("tbl%0d_ready", i), o_s_ready, tbl[i].exp_ready);
         @(posedge i_clk); #1;
         check($sformatf("tbl%0d_valid", i), o_pixel_data_valid, tbl[i].exp_valid);
         check($sformatf("tbl%0d_data", i), o_pixel_data, tbl[i].exp_data);
         check($sformatf("tbl%0d_credit", i), o_credit, tbl[i].exp_credit);
      end

      // Full frame with credit exhaustion and two returns.
      do_reset();
      cycle(1'b0, 1'b1, 8'hAA, 1'b0);
      cycle(1'b0, 1'b1, 8'hAB, 1'b0);
      cycle(1'b1, 1'b0, 8'h00, 1'b0);
      for (int k = 0; k < 24; k++) cycle(1'b0, 1'b1, 8'(k), 1'b0);
      check("exhaust_credit", o_credit, 0);
      check("exhaust_stall", o_stall, 1);
      check("exhaust_ready", o_s_ready, 0);
      cycle(1'b0, 1'b1, 8'd24, 1'b0);
      cycle(1'b0, 1'b1, 8'd24, 1'b1);
      check("intr1_credit", o_credit, 1);
      for (int k = 24; k < 32; k++) cycle(1'b0, 1'b1, 8'(k), 1'b0);
      check("line4_stall", o_stall, 1);
      cycle(1'b0, 1'b0, 8'd0, 1'b1);
      for (int k = 32; k < 40; k++) cycle(1'b0, 1'b1, 8'(k), 1'b0);
      check("frame_done_pulse", o_frame_done, 1);
      cycle(1'b1, 1'b1, 8'd99, 1'b0);
      check("frame_done_clear", o_frame_done, 0);
      check("idle_after_done", o_pixel_data_valid, 0);

      // Return coinciding with a first-pixel accept at credit 1, then a gappy line.
      cycle(1'b1, 1'b0, 8'd0, 1'b0);
      cycle(1'b0, 1'b0, 8'd0, 1'b1);
      cycle(1'b0, 1'b1, 8'h5A, 1'b1);
      check("coincident_credit", o_credit, 1);
      for (int k = 0; k < 14; k++) cycle(1'b0, (k % 2) == 0, 8'(8'h60 + k), 1'b0);

      // Over-return sets a sticky error.
      do_reset();
      cycle(1'b0, 1'b0, 8'd0, 1'b1);
      check("err_set", o_err, 1);
      check("err_credit", o_credit, 3);
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 8'd0, 1'b0);
      check("err_sticky", o_err, 1);

      // Reset in the middle of the second line, then a clean restart.
      do_reset();
      cycle(1'b1, 1'b0, 8'd0, 1'b0);
      for (int k = 0; k < 11; k++) cycle(1'b0, 1'b1, 8'(8'h80 + k), 1'b0);
      i_s_valid = 1'b1; i_s_data = 8'hEE;
      do_reset();
      cycle(1'b1, 1'b0, 8'd0, 1'b0);
      for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, 8'(8'hC0 + k), 1'b0);
      check("restart_credit", o_credit, 2);

      // Random traffic against the model.
      do_reset();
      for (int k = 0; k < 1500; k++) begin
         cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
               8'($urandom_range(0, 255)), $urandom_range(0, 11) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pixel_stream_feeder.md
Name: pixel_stream_feeder

Overview:
- Transmit-side partner of the line-buffered window generator.
- Accepts a ready/valid 8-bit pixel stream from the DMA/source side and drives the generator's pixel_data/pixel_data_valid input, which has no backpressure.
- Flow control is line-credit based: one credit per free line buffer, consumed per line sent, returned on each generator line-read interrupt, so buffers are never overwritten.
- Also frames the stream: pixel/line counting, line-done and frame-done pulses.

Parameters:
- LINE_WIDTH, 480, pixels per image line.
- NUM_LINE_BUFS, 7, line buffers in the downstream generator; also the initial and maximum credit.
- IMG_HEIGHT, 480, lines per frame.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous, active-low reset.
- i_start  input  1  one-cycle pulse; begins a frame when IDLE.
- i_s_data  input  8  source pixel.
- i_s_valid  input  1  source pixel valid.
- o_s_ready  output  1  feeder accepts source pixel this cycle.
- o_pixel_data  output  8  pixel to generator (registered).
- o_pixel_data_valid  output  1  pixel valid to generator (registered).
- i_intr  input  1  generator line-read-complete pulse; returns one credit.
- o_credit  output  clog2(NUM_LINE_BUFS+1)  current free-line credit.
- o_stall  output  1  SEND state, at a line boundary, with zero credit.
- o_line_done  output  1  one-cycle pulse with the last pixel of each line.
- o_frame_done  output  1  one-cycle pulse after the last line of a frame.
- o_err  output  1  sticky; i_intr received while credit == NUM_LINE_BUFS.

Behaviour:
- Reset (i_rst == 0 at a clock edge):
  - State IDLE.
  - o_pixel_data = 0, o_pixel_data_valid = 0, o_s_ready = 0.
  - o_line_done = 0, o_frame_done = 0, o_err = 0.
  - Pixel and line counters = 0; credit = NUM_LINE_BUFS.
  - Reset mid-line drops the partial line; no completion pulses are emitted.
- State machine: IDLE, SEND, DONE.
  - IDLE -> SEND on i_start. i_start in SEND or DONE is ignored.
  - SEND -> DONE on the accept of pixel LINE_WIDTH-1 of line IMG_HEIGHT-1.
  - DONE -> IDLE after one cycle; o_frame_done = 1 during DONE.
- Accept condition:
  - o_s_ready = (state == SEND) && (pix_cnt != 0 || credit != 0). This is combinational.
  - Accept = i_s_valid && o_s_ready.
- Output latency is 1 cycle. On an accept, the next cycle has o_pixel_data = i_s_data and o_pixel_data_valid = 1; otherwise valid = 0 and data holds.
- Credit:
  - An accept with pix_cnt == 0 consumes one credit (reserves the line).
  - i_intr adds one credit.
  - Both in the same cycle: credit unchanged.
  - i_intr at credit == NUM_LINE_BUFS with no consume: credit saturates and o_err sets (cleared only by reset).
  - Credit persists across frames; it is not reloaded by i_start.
  - i_intr is counted in every state.
- Counters:
  - pix_cnt increments per accept and wraps LINE_WIDTH-1 -> 0.
  - On the wrap: line_cnt increments, and o_line_done pulses in the same cycle as that pixel's o_pixel_data_valid.
  - line_cnt clears on the transition to DONE.
- o_stall = (state == SEND) && pix_cnt == 0 && credit == 0.
- Gaps in i_s_valid mid-line are allowed; the output valid simply has matching gaps.
- Implementation target: roughly 150-250 lines.

Test Plan:
- Bench parameters: LINE_WIDTH=8, NUM_LINE_BUFS=3, IMG_HEIGHT=5.
- Reset release then idle:
  - o_credit=3, o_s_ready=0, all outputs 0.
  - i_s_valid=1 in IDLE -> no o_pixel_data_valid.
- Start, continuous source (data = 0..255 ramp), no i_intr:
  - 24 pixels pass, each with 1-cycle latency and matching data.
  - o_line_done at output pixels 8, 16, 24.
  - o_credit goes 2, 1, 0.
  - Then o_s_ready=0 and o_stall=1.
- From the stalled state, pulse i_intr once:
  - o_credit=1, then line 4 (8 pixels) flows, o_credit=0, stall again.
  - Second i_intr -> line 5 flows -> o_frame_done one cycle after its last pixel -> IDLE.
- i_intr coincident with a first-pixel accept at credit=1:
  - o_credit stays 1.
  - Separately: i_intr at credit=3 -> o_credit=3, o_err=1 and stays 1.
- Source gaps (i_s_valid toggling 1,0,1,0 mid-line):
  - Output valid mirrors the pattern delayed by 1 cycle.
  - Pixel count per line is still 8.
- Reset asserted mid-line 2 (pixel 3):
  - Next cycle o_pixel_data_valid=0, o_credit=3, IDLE.
  - A new i_start restarts from pixel 0, line 0.
